// File: rtl/spi_slave_bridge_p.sv
// Parametrised SPI slave bridge, fully in the clk domain (oversampled sclk/cs_n/mosi).
// Optional frame_err output is enabled by defining SPI_FRAME_ERR_EN.
module spi_slave_bridge_p #(
  parameter int unsigned       WIDTH       = 8,
  parameter bit                CPOL        = 1'b0,
  parameter bit                CPHA        = 1'b0,
  parameter bit                MSB_FIRST   = 1'b1,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0]  IDLE_WORD   = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx_underrun,
  output logic             busy,
  output logic             frame_err
);

  localparam int unsigned CW = $clog2(WIDTH);

  // ST_RESET/ST_ARM make sure cs_n is seen high after reset before a fall can start a frame
  typedef enum logic [1:0] {ST_RESET, ST_ARM, ST_IDLE, ST_ACTIVE} state_t;
  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_hist, cs_hist;
  logic                   sclk_s, cs_s, mosi_s;

  logic                   lead_edge, trail_edge, edge_ok;
  logic                   sample_edge, shift_edge, tx_step;
  logic                   cs_fall, cs_rise, word_done, load, abort;

  logic [WIDTH-1:0]       hold, tx_sh, tx_next, load_word, rx_sh, rx_next;
  logic                   hold_valid, miso_r, underrun_r;
  logic [CW-1:0]          bit_cnt;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= {SYNC_STAGES{CPOL}};
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_hist <= CPOL;
      cs_hist   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_hist <= sclk_s;
      cs_hist   <= cs_s;
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign lead_edge   = (sclk_hist == CPOL) && (sclk_s != CPOL);
  assign trail_edge  = (sclk_hist != CPOL) && (sclk_s == CPOL);
  assign edge_ok     = (state == ST_ACTIVE) && !cs_s;
  assign sample_edge = edge_ok && (CPHA ? trail_edge : lead_edge);
  assign shift_edge  = edge_ok && (CPHA ? lead_edge : trail_edge);
  assign cs_fall     = cs_hist && !cs_s;
  assign cs_rise     = !cs_hist && cs_s;
  assign word_done   = sample_edge && (bit_cnt == CW'(WIDTH - 1));
  assign load        = ((state == ST_IDLE) && cs_fall) || word_done;
  assign abort       = (state == ST_ACTIVE) && cs_rise;

  // CPHA=0: the trailing edge right after a word's last sample must not shift,
  // because the next word's first bit was already driven by the load.
  assign tx_step   = shift_edge && (CPHA || (bit_cnt != '0));
  assign tx_next   = advance(tx_sh);
  assign load_word = hold_valid ? hold : IDLE_WORD;
  assign rx_next   = MSB_FIRST ? {rx_sh[WIDTH-2:0], mosi_s} : {mosi_s, rx_sh[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RESET;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RESET:  state_next = ST_ARM;
      ST_ARM:    if ((&cs_sync) && cs_hist) state_next = ST_IDLE;
      ST_IDLE:   if (cs_fall) state_next = ST_ACTIVE;
      ST_ACTIVE: if (cs_rise) state_next = ST_IDLE;
      default:   state_next = ST_RESET;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    miso_oe = 1'b0;
    if (state == ST_ACTIVE) begin
      busy    = 1'b1;
      miso_oe = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold       <= '0;
      hold_valid <= 1'b0;
      tx_sh      <= '0;
      miso_r     <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      underrun_r <= 1'b0;
      if (load) begin
        tx_sh      <= load_word;
        underrun_r <= !hold_valid;
        hold_valid <= 1'b0;
        if (!CPHA) miso_r <= first_bit(load_word);
      end else if (tx_step) begin
        tx_sh  <= tx_next;
        miso_r <= CPHA ? first_bit(tx_sh) : first_bit(tx_next);
      end else if (state != ST_ACTIVE || abort) begin
        tx_sh  <= '0;
        miso_r <= 1'b0;
      end
      if (tx_valid && !hold_valid) begin
        hold       <= tx_data;
        hold_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sh    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      bit_cnt  <= '0;
    end else begin
      rx_valid <= 1'b0;
      if (abort || state != ST_ACTIVE) begin
        rx_sh   <= '0;
        bit_cnt <= '0;
      end else if (sample_edge) begin
        rx_sh <= rx_next;
        if (word_done) begin
          rx_data  <= rx_next;
          rx_valid <= 1'b1;
          bit_cnt  <= '0;
        end else begin
          bit_cnt <= bit_cnt + CW'(1);
        end
      end
    end
  end

`ifdef SPI_FRAME_ERR_EN
  logic frame_err_r;
  always_ff @(posedge clk) begin
    if (rst) frame_err_r <= 1'b0;
    else     frame_err_r <= abort && (bit_cnt != '0);
  end
  assign frame_err = frame_err_r;
`else
  assign frame_err = 1'b0;
`endif

  assign miso        = miso_r;
  assign tx_ready    = !hold_valid;
  assign tx_underrun = underrun_r;

endmodule

// File: tb/tb_spi_slave_bridge_p.sv
// Self-checking bench for spi_slave_bridge_p: behavioural SPI master plus a word-level model
// of the TX hold register; six instances cover the base config, all modes and a 16-bit build.
module tb_spi_slave_bridge_p;
  localparam int HALF = 80;
  localparam int N    = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk_a[N], cs_a[N], mosi_a[N], miso_a[N], oe_a[N], busy_a[N];
  logic txv_a[N], txr_a[N], und_a[N], fe_a[N], rxv_a[N];
  logic [7:0]  rx8_a[5];
  logic [7:0]  txd8_a[5];
  logic [15:0] rx16, txd16;

  // per-instance configuration as the bench sees it
  bit          cpol_c[N]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  bit          cpha_c[N]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  bit          msb_c[N]   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  int          width_c[N] = '{8, 8, 8, 8, 8, 16};
  logic [15:0] idle_c[N]  = '{16'h00E7, 16'h0, 16'h0, 16'h0, 16'h0, 16'hC3A5};
  logic [15:0] mask_c[N]  = '{16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF, 16'hFFFF};

  int          rx_cnt[N], und_cnt[N], fe_cnt[N];
  logic [15:0] rx_last[N];
  logic [15:0] holdq[N][$];
  logic [15:0] cur_tx[N];
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  spi_slave_bridge_p #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1),
                       .SYNC_STAGES(2), .IDLE_WORD(8'hE7)) u_main (
    .clk(clk), .rst(rst), .sclk(sclk_a[0]), .cs_n(cs_a[0]), .mosi(mosi_a[0]),
    .miso(miso_a[0]), .miso_oe(oe_a[0]), .rx_data(rx8_a[0]), .rx_valid(rxv_a[0]),
    .tx_data(txd8_a[0]), .tx_valid(txv_a[0]), .tx_ready(txr_a[0]),
    .tx_underrun(und_a[0]), .busy(busy_a[0]), .frame_err(fe_a[0]));

  for (genvar k = 0; k < 4; k++) begin : g_mode
    spi_slave_bridge_p #(.WIDTH(8), .CPOL(k >= 2), .CPHA((k % 2) == 1),
                         .MSB_FIRST(1'b0)) u_mode (
      .clk(clk), .rst(rst), .sclk(sclk_a[k+1]), .cs_n(cs_a[k+1]), .mosi(mosi_a[k+1]),
      .miso(miso_a[k+1]), .miso_oe(oe_a[k+1]), .rx_data(rx8_a[k+1]), .rx_valid(rxv_a[k+1]),
      .tx_data(txd8_a[k+1]), .tx_valid(txv_a[k+1]), .tx_ready(txr_a[k+1]),
      .tx_underrun(und_a[k+1]), .busy(busy_a[k+1]), .frame_err(fe_a[k+1]));
  end

  spi_slave_bridge_p #(.WIDTH(16), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1),
                       .IDLE_WORD(16'hC3A5)) u_wide (
    .clk(clk), .rst(rst), .sclk(sclk_a[5]), .cs_n(cs_a[5]), .mosi(mosi_a[5]),
    .miso(miso_a[5]), .miso_oe(oe_a[5]), .rx_data(rx16), .rx_valid(rxv_a[5]),
    .tx_data(txd16), .tx_valid(txv_a[5]), .tx_ready(txr_a[5]),
    .tx_underrun(und_a[5]), .busy(busy_a[5]), .frame_err(fe_a[5]));

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rxv_a[i] === 1'b1) begin
        rx_cnt[i]++;
        if (i == N - 1) rx_last[i] = rx16;
        else            rx_last[i] = {8'h00, rx8_a[i]};
      end
      if (und_a[i] === 1'b1) und_cnt[i]++;
      if (fe_a[i] === 1'b1)  fe_cnt[i]++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string pre);
    chk({pre, "_rx_data"}, {24'h0, rx8_a[0]}, 0);
    chk({pre, "_rx_valid"}, rxv_a[0], 0);
    chk({pre, "_miso"}, miso_a[0], 0);
    chk({pre, "_miso_oe"}, oe_a[0], 0);
    chk({pre, "_busy"}, busy_a[0], 0);
    chk({pre, "_tx_ready"}, txr_a[0], 1);
    chk({pre, "_tx_underrun"}, und_a[0], 0);
    chk({pre, "_frame_err"}, fe_a[0], 0);
  endtask

  // Model of one word load: hold register contents if present, else IDLE_WORD with underrun.
  task automatic model_load(input int i, output bit und);
    if (holdq[i].size() != 0) begin
      cur_tx[i] = holdq[i].pop_front();
      und = 1'b0;
    end else begin
      cur_tx[i] = idle_c[i];
      und = 1'b1;
    end
  endtask

  task automatic offer(input int i, input logic [15:0] d);
    int n = 0;
    @(negedge clk);
    while (txr_a[i] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("tx_ready_wait", txr_a[i], 1);
    if (i == N - 1) txd16 = d;
    else            txd8_a[i] = d[7:0];
    txv_a[i] = 1'b1;
    @(negedge clk);
    txv_a[i] = 1'b0;
    holdq[i].push_back(d & mask_c[i]);
    chk("tx_ready_drop", txr_a[i], 0);
  endtask

  task automatic spi_bits(input int i, input logic [15:0] mw, input int nbits,
                          output logic [15:0] sw);
    int pos;
    sw = '0;
    for (int b = 0; b < nbits; b++) begin
      pos = msb_c[i] ? (width_c[i] - 1 - b) : b;
      if (!cpha_c[i]) begin
        mosi_a[i] = mw[pos];
        #HALF;
        sw[pos] = miso_a[i];
        sclk_a[i] = ~cpol_c[i];
        #HALF;
        sclk_a[i] = cpol_c[i];
      end else begin
        #HALF;
        sclk_a[i] = ~cpol_c[i];
        mosi_a[i] = mw[pos];
        #HALF;
        sw[pos] = miso_a[i];
        sclk_a[i] = cpol_c[i];
      end
    end
    #HALF;
  endtask

  task automatic frame_start(input int i);
    int u0;
    bit und;
    u0 = und_cnt[i];
    @(negedge clk);
    cs_a[i] = 1'b0;
    #(2*HALF);
    model_load(i, und);
    chk("start_busy", busy_a[i], 1);
    chk("start_miso_oe", oe_a[i], 1);
    chk("start_underrun", und_cnt[i] - u0, {31'h0, und});
  endtask

  task automatic word(input int i, input logic [15:0] mw, input string tag);
    logic [15:0] sw, exp_tx;
    int r0, u0;
    bit und;
    r0 = rx_cnt[i];
    u0 = und_cnt[i];
    exp_tx = cur_tx[i];
    spi_bits(i, mw, width_c[i], sw);
    chk({tag, "_rx_pulses"}, rx_cnt[i] - r0, 1);
    chk({tag, "_rx_data"}, {16'h0, rx_last[i]}, {16'h0, mw & mask_c[i]});
    chk({tag, "_master_got"}, {16'h0, sw}, {16'h0, exp_tx});
    model_load(i, und);
    chk({tag, "_underrun"}, und_cnt[i] - u0, {31'h0, und});
  endtask

  task automatic frame_end(input int i);
    cs_a[i] = 1'b1;
    #(2*HALF);
    chk("end_busy", busy_a[i], 0);
    chk("end_miso_oe", oe_a[i], 0);
    chk("end_miso", miso_a[i], 0);
  endtask

  initial begin
    logic [15:0] sw, rw, tw;
    int r0, f0, u0;
    bit und;
    for (int i = 0; i < N; i++) begin
      sclk_a[i] = cpol_c[i];
      cs_a[i]   = 1'b1;
      mosi_a[i] = 1'b0;
      txv_a[i]  = 1'b0;
    end
    for (int i = 0; i < 5; i++) txd8_a[i] = '0;
    txd16 = '0;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // basic transfer
    offer(0, 16'h00A5);
    frame_start(0);
    word(0, 16'h003C, "basic");
    frame_end(0);
    chk("basic_tx_ready_back", txr_a[0], 1);

    for (int n = 0; n < 3; n++) begin
      offer(0, 16'($urandom));
      frame_start(0);
      word(0, 16'($urandom), $sformatf("rand%0d", n));
      frame_end(0);
    end

    // all four SPI modes, LSB first
    for (int m = 1; m <= 4; m++) begin
      offer(m, 16'h005A);
      frame_start(m);
      word(m, 16'h0081, $sformatf("mode%0d", m - 1));
      frame_end(m);
      offer(m, 16'($urandom));
      frame_start(m);
      word(m, 16'($urandom), $sformatf("mode%0d_rand", m - 1));
      frame_end(m);
    end

    // two words in one frame, hold empty for the second
    offer(5, 16'h0F0F);
    frame_start(5);
    word(5, 16'h1234, "multi_w1");
    word(5, 16'hBEEF, "multi_w2");
    frame_end(5);

    // cs_n rise after 5 bits
    r0 = rx_cnt[0];
    f0 = fe_cnt[0];
    frame_start(0);
    spi_bits(0, 16'h00FF, 5, sw);
    cs_a[0] = 1'b1;
    #(2*HALF);
    chk("abort_no_rx", rx_cnt[0] - r0, 0);
    chk("abort_busy", busy_a[0], 0);
`ifdef SPI_FRAME_ERR_EN
    chk("abort_frame_err", fe_cnt[0] - f0, 1);
`else
    chk("abort_frame_err", fe_cnt[0] - f0, 0);
`endif
    tw = 16'($urandom);
    offer(0, tw);
    frame_start(0);
    word(0, 16'h0077, "after_abort");
    frame_end(0);
`ifdef SPI_FRAME_ERR_EN
    chk("abort_frame_err_once", fe_cnt[0] - f0, 1);
`else
    chk("abort_frame_err_once", fe_cnt[0] - f0, 0);
`endif

    // tx handshake in the same cycle as the cs_n-fall load
    chk("coll_hold_empty", txr_a[0], 1);
    u0 = und_cnt[0];
    @(negedge clk);
    cs_a[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    txd8_a[0] = 8'h55;
    txv_a[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    txv_a[0] = 1'b0;
    model_load(0, und);
    holdq[0].push_back(16'h0055);
    chk("coll_busy", busy_a[0], 1);
    chk("coll_tx_ready", txr_a[0], 0);
    #(2*HALF);
    chk("coll_underrun", und_cnt[0] - u0, {31'h0, und});
    word(0, 16'($urandom), "coll_w1");
    word(0, 16'($urandom), "coll_w2");
    frame_end(0);

    // reset in the middle of a frame with cs_n held low
    frame_start(0);
    spi_bits(0, 16'h00AA, 3, sw);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rstmid");
    for (int i = 0; i < N; i++) holdq[i].delete();
    rst = 1'b0;
    r0 = rx_cnt[0];
    rw = 16'h003C;
    spi_bits(0, rw, 8, sw);
    chk("rstmid_no_rx", rx_cnt[0] - r0, 0);
    chk("rstmid_busy", busy_a[0], 0);
    chk("rstmid_miso_oe", oe_a[0], 0);
    cs_a[0] = 1'b1;
    #(2*HALF);
    frame_start(0);
    word(0, 16'h0096, "post_rst");
    frame_end(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_slave_bridge_p.md
Name: spi_slave_bridge_p

Overview:
Parametrised SPI slave bridge, successor to the original fixed 8-bit, sclk-clocked bridge. Runs entirely in the peripheral clock domain: it oversamples sclk, cs_n and mosi through synchronisers and edge-detects sclk. Supports configurable word width, all four CPOL/CPHA modes and either bit order. Adds a buffered TX handshake, multi-word frames and an underrun flag. Sits between the external SPI master pins and the register-file or PWM control logic.

Parameters:
WIDTH, 8, bits per SPI word; legal range 4..32.
CPOL, 0, sclk idle level.
CPHA, 0, 0 = sample on leading edge and shift on trailing edge; 1 = shift on leading edge and sample on trailing edge.
MSB_FIRST, 1, 1 = MSB on the wire first; 0 = LSB first.
SYNC_STAGES, 2, synchroniser depth for sclk, cs_n and mosi; legal range 2..3.
IDLE_WORD, 0, word shifted out on miso when no TX data is buffered.

Ports:
clk  in  1  peripheral clock; f_clk >= 8 * f_sclk
rst  in  1  synchronous reset, active-high
sclk  in  1  SPI clock from master (asynchronous)
cs_n  in  1  chip select, active-low (asynchronous)
mosi  in  1  master-out data (asynchronous)
miso  out  1  slave-out data
miso_oe  out  1  miso output enable; high while the synchronised cs_n is low
rx_data  out  WIDTH  last complete received word
rx_valid  out  1  one-cycle pulse; rx_data is updated in the same cycle
tx_data  in  WIDTH  word to transmit
tx_valid  in  1  tx_data offered
tx_ready  out  1  TX hold register empty
tx_underrun  out  1  one-cycle pulse when IDLE_WORD is loaded because the hold register was empty
busy  out  1  frame active (synchronised cs_n low)
frame_err  out  1  see Optional Feature

Behaviour:
Reset state:
- rx_data=0, rx_valid=0, miso=0, miso_oe=0, busy=0, tx_ready=1, tx_underrun=0, frame_err=0.
- Hold register empty; bit counter 0; synchronisers loaded with idle values (sclk=CPOL, cs_n=1, mosi=0).

Synchronisation and edge detection:
- Signals pass through SYNC_STAGES flops, plus one history flop for edge detection.
- Leading edge = sclk leaving CPOL; trailing edge = sclk returning to CPOL.
- Edges are ignored while synchronised cs_n is high.

TX handshake:
- Transfer occurs on tx_valid && tx_ready: the hold register captures tx_data and tx_ready drops in the next cycle.
- tx_ready rises in the cycle after the hold register moves into the shift register.

Word load:
- Triggers: the cs_n falling-edge detect, or completion of the final sample of a word while cs_n is still low.
- The shift register takes the hold register and the hold register empties.
- If the hold register is empty, the shift register takes IDLE_WORD and tx_underrun pulses.
- No bypass: a tx_valid handshake in the same cycle as a load fills the hold register for the next word, and underrun still flags.

miso drive:
- CPHA=0: first bit is driven in the cycle after the load; each later bit changes on a trailing edge.
- CPHA=1: each bit, including the first, is driven on a leading edge.
- Bit order follows MSB_FIRST.

RX path:
- The synchronised mosi is shifted in on each sample edge and the bit counter increments.
- When the counter reaches WIDTH: rx_data takes the assembled word and rx_valid pulses in the cycle after the sample-edge detect.
- The counter then wraps to 0, so back-to-back words within one frame are supported without gaps.

cs_n rise mid-word:
- Partial RX word discarded; rx_valid not asserted.
- Counter cleared.
- The word in the shift register is dropped; the hold register is kept.

Frame boundaries:
- cs_n rise: miso_oe=0 and busy=0 in the cycle after the cs_n rising-edge detect.
- miso returns to 0 when cs_n is high.

Reset:
- rst mid-frame aborts immediately to the reset state.
- After rst deasserts, the block waits for a fresh cs_n falling edge; an already-low cs_n does not start a frame.

Optional Feature:
Macro SPI_FRAME_ERR_EN.
- Defined: frame_err pulses for one cycle when cs_n rises with a nonzero bit counter (partial word).
- Not defined: frame_err is tied to 0, and no extra logic is generated.

Test Plan:
- Reset: WIDTH=8, CPOL=0, CPHA=0, MSB_FIRST=1; load tx 0xA5; master sends 0x3C -> rx_data=0x3C with one rx_valid pulse; master captures 0xA5; tx_ready returns to 1.
- Modes: sweep CPOL/CPHA over all 4 combinations with MSB_FIRST=0, master 0x81 / slave 0x5A -> both sides receive the correct word in every mode.
- Multi-word frame: WIDTH=16, hold register empty after word 1, master sends 0x1234 then 0xBEEF in one cs_n frame -> rx_valid twice (0x1234, then 0xBEEF); second tx word = IDLE_WORD with one tx_underrun pulse.
- cs_n rise after 5 bits -> no rx_valid, counter cleared; next full frame 0x77 received correctly; frame_err=1 for one cycle only with SPI_FRAME_ERR_EN defined.
- Handshake collision: tx_valid with 0x55 in the same cycle as the cs_n-fall load, hold register empty -> first word IDLE_WORD plus tx_underrun; second word 0x55.
- Reset mid-frame: rst asserted after 3 bits with cs_n held low -> all outputs at reset values; no rx_valid until cs_n toggles high then low again.
